// File: rtl/regfile_z_nr1w_sweep_if.sv
// Bus bundle for the zero-entry register file: one write port, P_NRD read ports,
// a clear request and a busy flag raised while the clear sweep runs.
interface regfile_z_nr1w_sweep_if #(
  parameter int P_NREGS = 32,
  parameter int P_NBITS = 32,
  parameter int P_NRD   = 2
);
  localparam int AW = $clog2(P_NREGS);

  // No valid/ready pair: wen qualifies waddr/wdata in the cycle it is high, and
  // the write is silently dropped while busy=1 or clear=1 (no backpressure, no retry).
  logic                     clear;
  logic                     busy;
  logic                     wen;
  logic [AW-1:0]            waddr;
  logic [P_NBITS-1:0]       wdata;
  logic [P_NRD*AW-1:0]      raddr;
  logic [P_NRD*P_NBITS-1:0] rdata;
  logic                     dbg_sweep;

  modport master (
    output clear, wen, waddr, wdata, raddr,
    input  busy, rdata, dbg_sweep
  );

  modport slave (
    input  clear, wen, waddr, wdata, raddr,
    output busy, rdata, dbg_sweep
  );
endinterface

// File: rtl/regfile_z_nr1w_sweep.sv
// Register file with P_NRD combinational read ports, one write port, a hard-wired
// zero entry 0, optional write bypass and a one-entry-per-cycle clear sweep.
module regfile_z_nr1w_sweep #(
  parameter int P_NREGS  = 32,
  parameter int P_NBITS  = 32,
  parameter int P_NRD    = 2,
  parameter int P_BYPASS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_z_nr1w_sweep_if.slave  bus
);
  localparam int AW = $clog2(P_NREGS);
  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(P_NREGS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t             state;
  logic [AW-1:0]      idx;
  logic [P_NBITS-1:0] mem [P_NREGS];
  logic               busy_i;
  logic               wr_ok;

  // rst is folded in so reads are already forced to zero during the reset cycle.
  assign busy_i        = rst | (state == SWEEP);
  assign bus.busy      = busy_i;
  assign bus.dbg_sweep = (state == SWEEP);
  assign wr_ok         = (state == IDLE) && !bus.clear && bus.wen && (bus.waddr != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SWEEP;
      idx   <= IDX_FIRST;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear) begin
            state <= SWEEP;
            idx   <= IDX_FIRST;
          end
        end
        SWEEP: begin
          // idx holds at the last entry instead of wrapping back to 0.
          if (idx == IDX_LAST) begin
            state <= IDLE;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        default: begin
          state <= SWEEP;
          idx   <= IDX_FIRST;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the sweep is what brings it to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == SWEEP) begin
        mem[idx] <= '0;
      end else if (wr_ok) begin
        mem[bus.waddr] <= bus.wdata;
      end
    end
  end

  logic [P_NRD*P_NBITS-1:0] rdata_i;

  for (genvar k = 0; k < P_NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = bus.raddr[k*AW +: AW];
    assign hit = (P_BYPASS != 0) && bus.wen && !bus.clear && (bus.waddr == ra);
    assign rdata_i[k*P_NBITS +: P_NBITS] =
      (busy_i || (ra == '0)) ? '0 :
      hit                    ? bus.wdata :
                               mem[ra];
  end

  assign bus.rdata = rdata_i;
endmodule
